// File: rtl/rfile_sb_if.sv
// Bus bundle for rfile_sb: two read ports with valid flags, the writeback
// port, the issue port and the clear-in-progress flag.
interface rfile_sb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              RV1;
  logic              RV2;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              ISS_EN;
  logic [ADDR_W-1:0] ISS_A;
  logic              INIT_BUSY;

  modport master (
    output A1, A2, WE3, A3, WD3, ISS_EN, ISS_A,
    input  RD1, RD2, RV1, RV2, INIT_BUSY
  );

  modport slave (
    input  A1, A2, WE3, A3, WD3, ISS_EN, ISS_A,
    output RD1, RD2, RV1, RV2, INIT_BUSY
  );
endinterface

// File: rtl/rfile_sb.sv
// 2-read/1-write register file with a post-reset clear sweep, a per-register
// busy scoreboard for in-flight producers, and write-first read bypass.
module rfile_sb_rdport #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] mem_d,
  input  logic              busy_b,
  output logic [DATA_W-1:0] rd,
  output logic              rv
);
  always_comb begin
    rd = '0;
    rv = 1'b0;
    if (run) begin
      if (ZERO_REG && addr == '0) begin
        rd = '0;
        rv = 1'b1;
      end else if (we && wa == addr) begin
        // writeback in this cycle satisfies the pending producer
        rd = wd;
        rv = 1'b1;
      end else begin
        rd = mem_d;
        rv = !busy_b;
      end
    end
  end
endmodule

module rfile_sb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic      CLK,
  input  logic      RST,
  rfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam int NPORT = 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic                    run;
  logic                    wr_ok, iss_ok;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_wa;
  logic [DATA_W-1:0]       mem_wd;
  logic [NPORT-1:0][ADDR_W-1:0] ra;
  logic [NPORT-1:0][DATA_W-1:0] rd;
  logic [NPORT-1:0]             rv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (&clr_idx) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign run    = (state == RUN);
  assign wr_ok  = run && bus.WE3 && !(ZR && bus.A3 == '0);
  assign iss_ok = run && bus.ISS_EN && !(ZR && bus.ISS_A == '0);

  // RST edge itself never writes; the sweep owns the port while clearing
  always_comb begin
    mem_we = 1'b0;
    mem_wa = bus.A3;
    mem_wd = bus.WD3;
    if (!RST) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_idx;
        mem_wd = '0;
      end else begin
        mem_we = wr_ok;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // issue is applied after the write so it wins on a same-register collision
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[bus.A3]    <= 1'b0;
      if (iss_ok) busy[bus.ISS_A] <= 1'b1;
    end
  end

  assign ra[0] = bus.A1;
  assign ra[1] = bus.A2;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    rfile_sb_rdport #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ZERO_REG(ZR)
    ) u_rd (
      .run   (run),
      .addr  (ra[p]),
      .we    (bus.WE3),
      .wa    (bus.A3),
      .wd    (bus.WD3),
      .mem_d (mem[ra[p]]),
      .busy_b(busy[ra[p]]),
      .rd    (rd[p]),
      .rv    (rv[p])
    );
  end

  assign bus.RD1       = rd[0];
  assign bus.RD2       = rd[1];
  assign bus.RV1       = rv[0];
  assign bus.RV2       = rv[1];
  assign bus.INIT_BUSY = !run;
endmodule

// File: tb/tb_rfile_sb.sv
// Directed bench for rfile_sb: default 32x32 instance plus an 8x8 instance
// without a hardwired zero register.
module tb_rfile_sb;
  logic CLK;
  logic RST;
  logic RST1;
  int   checks = 0;
  int   errors = 0;

  rfile_sb_if #(.ADDR_W(5), .DATA_W(32)) f0 ();
  rfile_sb_if #(.ADDR_W(3), .DATA_W(8))  f1 ();

  rfile_sb #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1)) u0 (
    .CLK(CLK), .RST(RST),  .bus(f0.slave)
  );
  rfile_sb #(.ADDR_W(3), .DATA_W(8),  .ZERO_REG(0)) u1 (
    .CLK(CLK), .RST(RST1), .bus(f1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle0();
    f0.WE3 = 0; f0.A3 = '0; f0.WD3 = '0; f0.ISS_EN = 0; f0.ISS_A = '0;
  endtask

  int  n;
  bit  rv_bad;

  initial begin
    RST = 1; RST1 = 1;
    f0.A1 = '0; f0.A2 = '0; idle0();
    f1.A1 = '0; f1.A2 = '0; f1.WE3 = 0; f1.A3 = '0; f1.WD3 = '0;
    f1.ISS_EN = 0; f1.ISS_A = '0;

    // single-cycle reset, then time the clear sweep
    step();
    RST = 0;
    #1;
    chk("rst_init_busy", f0.INIT_BUSY, 1);
    chk("rst_rd1", f0.RD1, 0);
    chk("rst_rd2", f0.RD2, 0);
    chk("rst_rv", {f0.RV1, f0.RV2}, 0);
    n = 0; rv_bad = 0;
    while (f0.INIT_BUSY === 1'b1 && n < 100) begin
      if (f0.RV1 !== 1'b0 || f0.RV2 !== 1'b0) rv_bad = 1;
      step();
      n++;
    end
    chk("clear_len", n, 32);
    chk("clear_rv_low", rv_bad, 0);

    f0.A1 = 5; f0.A2 = 31; #1;
    chk("post_clr_rd1", f0.RD1, 0);
    chk("post_clr_rd2", f0.RD2, 0);
    chk("post_clr_rv", {f0.RV1, f0.RV2}, 2'b11);

    // write with same-cycle bypass
    f0.WE3 = 1; f0.A3 = 7; f0.WD3 = 32'hDEADBEEF; f0.A1 = 7; #1;
    chk("byp_rd1", f0.RD1, 32'hDEADBEEF);
    chk("byp_rv1", f0.RV1, 1);
    step(); idle0(); #1;
    chk("stored_rd1", f0.RD1, 32'hDEADBEEF);
    chk("stored_rv1", f0.RV1, 1);

    // scoreboard: issue then writeback
    f0.ISS_EN = 1; f0.ISS_A = 9;
    step(); idle0(); f0.A2 = 9; #1;
    chk("iss_rv2", f0.RV2, 0);
    f0.WE3 = 1; f0.A3 = 9; f0.WD3 = 32'h1234; #1;
    chk("wb_byp_rv2", f0.RV2, 1);
    chk("wb_byp_rd2", f0.RD2, 32'h1234);
    step(); idle0(); #1;
    chk("wb_rv2", f0.RV2, 1);
    chk("wb_rd2", f0.RD2, 32'h1234);

    // issue and write to the same register: data lands, busy remains
    f0.ISS_EN = 1; f0.ISS_A = 12; f0.WE3 = 1; f0.A3 = 12; f0.WD3 = 32'h55;
    step(); idle0(); f0.A1 = 12; f0.A2 = 12; #1;
    chk("coll_rd1", f0.RD1, 32'h55);
    chk("coll_rv1", f0.RV1, 0);
    chk("coll_both_ports", {f0.RD2, f0.RV2}, {32'h55, 1'b0});

    // register 0 is hardwired
    f0.ISS_EN = 1; f0.ISS_A = 0; f0.WE3 = 1; f0.A3 = 0; f0.WD3 = 32'hFF;
    f0.A1 = 0; #1;
    chk("zero_byp", {f0.RD1, f0.RV1}, {32'h0, 1'b1});
    step(); idle0(); #1;
    chk("zero_rd1", f0.RD1, 0);
    chk("zero_rv1", f0.RV1, 1);

    // reset restarted at clear cycle 10, traffic during clear is dropped
    RST = 1; step(); RST = 0;
    repeat (10) step();
    RST = 1; step(); RST = 0;
    f0.WE3 = 1; f0.A3 = 3; f0.WD3 = 32'h77; f0.ISS_EN = 1; f0.ISS_A = 4;
    f0.A1 = 3; f0.A2 = 4; #1;
    chk("clr_no_byp", {f0.RD1, f0.RV1}, {32'h0, 1'b0});
    n = 0;
    while (f0.INIT_BUSY === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("restart_clear_len", n, 32);
    idle0(); #1;
    chk("clr_wr_dropped", {f0.RD1, f0.RV1}, {32'h0, 1'b1});
    chk("clr_iss_dropped", {f0.RD2, f0.RV2}, {32'h0, 1'b1});
    f0.A1 = 7; f0.A2 = 12; #1;
    chk("clr_wiped_r7", f0.RD1, 0);
    chk("clr_busy_r12", f0.RV2, 1);

    // small instance, no zero register
    RST1 = 0; #1;
    n = 0;
    while (f1.INIT_BUSY === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("p_clear_len", n, 8);
    f1.WE3 = 1; f1.A3 = 0; f1.WD3 = 8'hA5;
    step(); f1.WE3 = 0; f1.A1 = 0; #1;
    chk("p_r0_rd", f1.RD1, 8'hA5);
    chk("p_r0_rv", f1.RV1, 1);
    f1.ISS_EN = 1; f1.ISS_A = 0;
    step(); f1.ISS_EN = 0; #1;
    chk("p_r0_busy", f1.RV1, 0);
    chk("p_r0_data", f1.RD1, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
